// File: rtl/cdr_loop_ctrl.sv
// cdr_loop_ctrl: CDR loop controller, vote-driven period retune with IDLE/ACQ/TRACK/LOCKED sequencing; optional holdover under CDR_HOLDOVER_EN
module cdr_loop_ctrl #(
   parameter int P_W        = 6,
   parameter int NOM_P      = 25,
   parameter int ACQ_STEP   = 2,
   parameter int ACQ_SPAN   = 4,
   parameter int TRK_STEP   = 1,
   parameter int TRK_SPAN   = 2,
   parameter int VOTE_W     = 4,
   parameter int ACQ_THR    = 2,
   parameter int TRK_THR    = 4,
   parameter int ACQ_QUIET  = 4,
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_CNT = 3
`ifdef CDR_HOLDOVER_EN
   ,
   parameter int HOLD_TICKS = 3
`endif
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_start,
   input  logic           i_T,
   input  logic           i_E,
   input  logic           i_tick,
   output logic [P_W-1:0] o_nb_P,
   output logic [1:0]     o_state,
   output logic           o_locked,
   output logic           o_adj_up,
   output logic           o_adj_dn,
   output logic           o_holdover
);
   typedef enum logic [1:0] {S_IDLE, S_ACQ, S_TRACK, S_LOCKED} state_t;
   localparam int CW       = 8;
   localparam int L_ACQ_LO = NOM_P - ACQ_SPAN;
   localparam int L_ACQ_HI = NOM_P + ACQ_SPAN;
   localparam int L_TRK_LO = NOM_P - TRK_SPAN;
   localparam int L_TRK_HI = NOM_P + TRK_SPAN;
   localparam logic [P_W:0] C_NOM      = NOM_P[P_W:0];
   localparam logic [P_W:0] C_ACQ_LO   = L_ACQ_LO[P_W:0];
   localparam logic [P_W:0] C_ACQ_HI   = L_ACQ_HI[P_W:0];
   localparam logic [P_W:0] C_TRK_LO   = L_TRK_LO[P_W:0];
   localparam logic [P_W:0] C_TRK_HI   = L_TRK_HI[P_W:0];
   localparam logic [P_W:0] C_ACQ_STEP = ACQ_STEP[P_W:0];
   localparam logic [P_W:0] C_TRK_STEP = TRK_STEP[P_W:0];
   localparam logic signed [VOTE_W-1:0] C_ACQ_THR = ACQ_THR[VOTE_W-1:0];
   localparam logic signed [VOTE_W-1:0] C_TRK_THR = TRK_THR[VOTE_W-1:0];
   localparam logic signed [VOTE_W-1:0] C_ONE     = VOTE_W'(1);
   localparam logic signed [VOTE_W-1:0] C_VMAX    = {1'b0, {(VOTE_W-1){1'b1}}};
   localparam logic signed [VOTE_W-1:0] C_VMIN    = -C_VMAX;
   localparam logic [CW-1:0] C_ACQ_Q  = ACQ_QUIET[CW-1:0];
   localparam logic [CW-1:0] C_LOCK   = LOCK_CNT[CW-1:0];
   localparam logic [CW-1:0] C_UNLOCK = UNLOCK_CNT[CW-1:0];

   state_t                     r_state, w_state_nxt;
   logic [P_W-1:0]             r_nb;
   logic signed [VOTE_W-1:0]   r_vote, w_vote_nxt, w_seed, w_thr;
   logic [CW-1:0]              r_q, r_c, w_q_inc, w_c_inc, w_q_nxt, w_c_nxt;
   logic                       r_up, r_dn;
   logic [P_W:0]               w_nbx, w_step, w_lo, w_hi, w_sum, w_dif, w_nb_corr, w_trk_clamp, w_nb_nxt;
   logic                       w_acq, w_want_up, w_want_dn, w_corr, w_at_bnd, w_frz, w_tick_act;

   assign w_acq       = r_state == S_ACQ;
   assign w_nbx       = {1'b0, r_nb};
   assign w_step      = w_acq ? C_ACQ_STEP : C_TRK_STEP;
   assign w_lo        = w_acq ? C_ACQ_LO : C_TRK_LO;
   assign w_hi        = w_acq ? C_ACQ_HI : C_TRK_HI;
   assign w_thr       = w_acq ? C_ACQ_THR : C_TRK_THR;
   assign w_want_up   = r_vote >= w_thr;
   assign w_want_dn   = r_vote <= -w_thr;
   assign w_corr      = w_want_up || w_want_dn;
   assign w_sum       = w_nbx + w_step;
   assign w_dif       = w_nbx - w_step;
   assign w_nb_corr   = w_want_up ? (w_sum > w_hi ? w_hi : w_sum) :
                        w_want_dn ? ((w_dif[P_W] || w_dif < w_lo) ? w_lo : w_dif) : w_nbx;
   assign w_at_bnd    = (w_want_up && w_nbx >= w_hi) || (w_want_dn && w_nbx <= w_lo);
   assign w_trk_clamp = w_nbx > C_TRK_HI ? C_TRK_HI : w_nbx < C_TRK_LO ? C_TRK_LO : w_nbx;
   assign w_q_inc     = (&r_q) ? r_q : r_q + CW'(1);
   assign w_c_inc     = (&r_c) ? r_c : r_c + CW'(1);
   assign w_seed      = i_T ? (i_E ? C_ONE : -C_ONE) : '0;
   assign w_vote_nxt  = !i_T ? r_vote :
                        i_E ? (r_vote == C_VMAX ? r_vote : r_vote + C_ONE) :
                              (r_vote == C_VMIN ? r_vote : r_vote - C_ONE);
   assign w_tick_act  = i_tick && r_state != S_IDLE && !w_frz;

   // Tick decision: default correction/counter update, overridden by state transitions
   always_comb begin
      w_state_nxt = r_state;
      w_nb_nxt    = w_nb_corr;
      w_q_nxt     = w_corr ? '0 : w_q_inc;
      w_c_nxt     = w_corr ? w_c_inc : '0;
      if (r_state == S_ACQ && !w_corr && w_q_inc >= C_ACQ_Q) begin
         w_state_nxt = S_TRACK;
         w_nb_nxt    = w_trk_clamp;
         w_q_nxt     = '0;
         w_c_nxt     = '0;
      end else if (r_state == S_TRACK && w_at_bnd) begin
         w_state_nxt = S_ACQ;
         w_q_nxt     = '0;
         w_c_nxt     = '0;
      end else if (r_state == S_TRACK && !w_corr && w_q_inc >= C_LOCK) begin
         w_state_nxt = S_LOCKED;
         w_q_nxt     = '0;
         w_c_nxt     = '0;
      end else if (r_state == S_LOCKED && w_corr && w_c_inc >= C_UNLOCK) begin
         w_state_nxt = S_TRACK;
         w_q_nxt     = '0;
         w_c_nxt     = '0;
      end
   end

   // Loop FSM: start restarts acquisition and discards a coincident tick
   always_ff @(posedge i_clk) begin
      if (i_rst || i_start) begin
         r_state <= i_rst ? S_IDLE : S_ACQ;
         r_nb    <= C_NOM[P_W-1:0];
         r_vote  <= '0;
         r_q     <= '0;
         r_c     <= '0;
         r_up    <= 1'b0;
         r_dn    <= 1'b0;
      end else begin
         r_up   <= w_tick_act && w_nb_nxt > w_nbx;
         r_dn   <= w_tick_act && w_nb_nxt < w_nbx;
         r_vote <= r_state == S_IDLE ? '0 : i_tick ? w_seed : w_vote_nxt;
         if (w_tick_act) begin
            r_state <= w_state_nxt;
            r_nb    <= w_nb_nxt[P_W-1:0];
            r_q     <= w_q_nxt;
            r_c     <= w_c_nxt;
         end
      end
   end

`ifdef CDR_HOLDOVER_EN
   localparam logic [CW-1:0] C_HOLD = HOLD_TICKS[CW-1:0];
   logic          r_hold, r_seen;
   logic [CW-1:0] r_sil, w_sil_inc;
   assign w_sil_inc = (&r_sil) ? r_sil : r_sil + CW'(1);
   assign w_frz     = r_hold;
   // Silent-window tracking: freeze the loop after enough windows without transitions
   always_ff @(posedge i_clk) begin
      if (i_rst || i_start) begin
         r_hold <= 1'b0;
         r_seen <= 1'b0;
         r_sil  <= '0;
      end else begin
         r_seen <= i_tick ? i_T : (r_seen | i_T);
         if (r_hold) begin
            if (i_T) begin
               r_hold <= 1'b0;
               r_sil  <= '0;
            end
         end else if (i_tick) begin
            if ((r_state == S_TRACK || r_state == S_LOCKED) && !r_seen) begin
               r_sil  <= w_sil_inc;
               r_hold <= w_sil_inc >= C_HOLD;
            end else begin
               r_sil <= '0;
            end
         end
      end
   end
   assign o_holdover = r_hold;
`else
   assign w_frz      = 1'b0;
   assign o_holdover = 1'b0;
`endif

   assign o_nb_P   = r_nb;
   assign o_state  = r_state;
   assign o_locked = r_state == S_LOCKED;
   assign o_adj_up = r_up;
   assign o_adj_dn = r_dn;
endmodule

// File: tb/tb_cdr_loop_ctrl.sv
// tb_cdr_loop_ctrl: directed bench for cdr_loop_ctrl (holdover steps active when CDR_HOLDOVER_EN is defined)
module tb_cdr_loop_ctrl;
   logic       clk, rst, start, t, e, tick;
   logic [5:0] nb;
   logic [1:0] st;
   logic       locked, up, dn, hold;
   int         total = 0;
   int         bad = 0;

   cdr_loop_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_T(t), .i_E(e), .i_tick(tick),
      .o_nb_P(nb), .o_state(st), .o_locked(locked), .o_adj_up(up), .o_adj_dn(dn),
      .o_holdover(hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic vt, input logic ve, input logic vk, input logic vs);
      t = vt;
      e = ve;
      tick = vk;
      start = vs;
      @(negedge clk);
   endtask

   task automatic win(input int n_early, input int n_late);
      for (int i = 0; i < n_early; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < n_late; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) win(1, 1);
   endtask

   initial begin
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_nb", 8'(nb), 8'd25);
      chk("rst_state", 8'(st), 8'd0);
      chk("rst_pulses", 8'({locked, up, dn, hold}), 8'd0);
      rst = 1'b0;
      win(3, 0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("idle_nb", 8'(nb), 8'd25);
      chk("idle_state", 8'(st), 8'd0);
      chk("idle_up", 8'(up), 8'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("start_state", 8'(st), 8'd1);
      win(3, 0);
      chk("acq1_nb", 8'(nb), 8'd27);
      chk("acq1_up", 8'(up), 8'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("acq1_up_drop", 8'(up), 8'd0);
      win(3, 0);
      chk("acq2_nb", 8'(nb), 8'd29);
      chk("acq2_up", 8'(up), 8'd1);
      win(3, 0);
      chk("acq3_nb", 8'(nb), 8'd29);
      chk("acq3_clamp_up", 8'(up), 8'd0);
      win(3, 0);
      chk("acq4_nb", 8'(nb), 8'd29);
      chk("acq4_state", 8'(st), 8'd1);
      quiet(3);
      chk("acq_q3_state", 8'(st), 8'd1);
      quiet(1);
      chk("trk_state", 8'(st), 8'd2);
      chk("trk_entry_nb", 8'(nb), 8'd27);
      quiet(7);
      chk("trk_q7_state", 8'(st), 8'd2);
      chk("trk_q7_locked", 8'(locked), 8'd0);
      quiet(1);
      chk("lock_state", 8'(st), 8'd3);
      chk("lock_locked", 8'(locked), 8'd1);
      win(0, 5);
      chk("lk_26_nb", 8'(nb), 8'd26);
      chk("lk_26_dn", 8'(dn), 8'd1);
      quiet(1);
      win(0, 5);
      quiet(1);
      chk("lk_25_nb", 8'(nb), 8'd25);
      chk("lk_25_state", 8'(st), 8'd3);
      win(0, 5);
      chk("ul1_nb", 8'(nb), 8'd24);
      chk("ul1_state", 8'(st), 8'd3);
      win(0, 5);
      chk("ul2_nb", 8'(nb), 8'd23);
      chk("ul2_state", 8'(st), 8'd3);
      win(0, 5);
      chk("ul3_nb", 8'(nb), 8'd23);
      chk("ul3_dn", 8'(dn), 8'd0);
      chk("ul3_state", 8'(st), 8'd2);
      chk("ul3_locked", 8'(locked), 8'd0);
      win(0, 5);
      chk("trk_bnd_state", 8'(st), 8'd1);
      chk("trk_bnd_nb", 8'(nb), 8'd23);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk("st_tick_nb", 8'(nb), 8'd25);
      chk("st_tick_state", 8'(st), 8'd1);
      chk("st_tick_pulse", 8'({up, dn}), 8'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("st_vote_clr_nb", 8'(nb), 8'd25);
      win(10, 9);
      chk("sat_nb", 8'(nb), 8'd23);
      chk("sat_dn", 8'(dn), 8'd1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("seed_tick_nb", 8'(nb), 8'd23);
      win(1, 0);
      chk("seed_nb", 8'(nb), 8'd25);
      chk("seed_up", 8'(up), 8'd1);
      quiet(12);
      chk("relock_state", 8'(st), 8'd3);
      chk("relock_nb", 8'(nb), 8'd25);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef CDR_HOLDOVER_EN
      chk("hold_on", 8'(hold), 8'd1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("hold_nb", 8'(nb), 8'd25);
      chk("hold_state", 8'(st), 8'd3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("hold_off", 8'(hold), 8'd0);
`else
      chk("nohold", 8'(hold), 8'd0);
      chk("nohold_state", 8'(st), 8'd3);
`endif
      win(0, 5);
      chk("post_silent_nb", 8'(nb), 8'd24);
      chk("post_silent_dn", 8'(dn), 8'd1);
      chk("post_silent_state", 8'(st), 8'd3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
